// File: rtl/cnn_sdiv_22s_8s_14_seq.sv
// cnn_sdiv_22s_8s_14_seq: sequential signed restoring divider, truncating toward zero.
// Define CNN_SDIV_SAT_EN to saturate out-of-range quotients instead of wrapping.
module cnn_sdiv_22s_8s_14_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 22,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 14
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [din0_WIDTH-1:0]        din0,
    input  logic [din1_WIDTH-1:0]        din1,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [dout_WIDTH-1:0]        dout,
    output logic [din1_WIDTH-1:0]        rem,
    output logic                         ovf,
    output logic                         dz
);
    localparam int CW = $clog2(din0_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0]           cnt;
    logic [din0_WIDTH-1:0]   q, a_mag;
    logic [din1_WIDTH:0]     r, d, b_mag;
    logic [din1_WIDTH+1:0]   r_sh, r_sub;
    logic                    q_neg, r_neg, zero, wrap;
    logic signed [din0_WIDTH:0]   q_s, q_ext;
    logic [dout_WIDTH-1:0]   q_lo, q_max, q_min, q_res, dz_val;
    assign in_rdy  = state == IDLE;
    assign out_vld = state == DONE;
    assign a_mag = din0[din0_WIDTH-1] ? -din0 : din0;
    assign b_mag = {1'b0, din1[din1_WIDTH-1] ? -din1 : din1};
    // r < d <= 2^(din1_WIDTH-1), so the borrow bit of r_sub alone decides the step
    assign r_sh  = {r, q[din0_WIDTH-1]};
    assign r_sub = r_sh - {1'b0, d};
    assign q_s   = q_neg ? -$signed({1'b0, q}) : $signed({1'b0, q});
    assign q_lo  = q_s[dout_WIDTH-1:0];
    assign q_ext = {{(din0_WIDTH + 1 - dout_WIDTH){q_lo[dout_WIDTH-1]}}, q_lo};
    assign wrap  = q_ext != q_s;
    assign q_max = {1'b0, {(dout_WIDTH-1){1'b1}}};
    assign q_min = {1'b1, {(dout_WIDTH-1){1'b0}}};
`ifdef CNN_SDIV_SAT_EN
    assign q_res  = wrap ? (q_s[din0_WIDTH] ? q_min : q_max) : q_lo;
    assign dz_val = r_neg ? q_min : q_max;
`else
    assign q_res  = q_lo;
    assign dz_val = '0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_vld ? CALC : IDLE;
            CALC:    state_nx = cnt == '0 ? DONE : CALC;
            DONE:    state_nx = out_rdy ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else if (ce) state <= state_nx;
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            zero  <= 1'b0;
            dout  <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
            dz    <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: if (in_vld) begin
                    q     <= a_mag;
                    d     <= b_mag;
                    r     <= '0;
                    q_neg <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                    r_neg <= din0[din0_WIDTH-1];
                    zero  <= din1 == '0;
                    cnt   <= din1 == '0 ? '0 : CW'(din0_WIDTH);
                end
                CALC: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                    q   <= {q[din0_WIDTH-2:0], ~r_sub[din1_WIDTH+1]};
                    r   <= r_sub[din1_WIDTH+1] ? r_sh[din1_WIDTH:0] : r_sub[din1_WIDTH:0];
                end else begin
                    dout <= zero ? dz_val : q_res;
                    rem  <= zero ? '0 : (r_neg ? -r[din1_WIDTH-1:0] : r[din1_WIDTH-1:0]);
                    ovf  <= ~zero & wrap;
                    dz   <= zero;
                end
                DONE: if (out_rdy) begin
                    ovf <= 1'b0;
                    dz  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_sdiv_22s_8s_14_seq.sv
// tb_cnn_sdiv_22s_8s_14_seq: directed vectors with hand-computed quotients/remainders.
// Expectations follow CNN_SDIV_SAT_EN the same way the design does.
module tb_cnn_sdiv_22s_8s_14_seq;
`ifdef CNN_SDIV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic        ap_clk = 1'b0, ap_rst_n = 1'b0, ce = 1'b1, in_vld = 1'b0, out_rdy = 1'b0;
    logic [21:0] din0 = '0;
    logic [7:0]  din1 = '0;
    logic        in_rdy, out_vld, ovf, dz;
    logic [13:0] dout;
    logic [7:0]  rem;
    int checks = 0, errors = 0;

    cnn_sdiv_22s_8s_14_seq dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_vld(in_vld), .in_rdy(in_rdy),
        .din0(din0), .din1(din1), .out_vld(out_vld), .out_rdy(out_rdy),
        .dout(dout), .rem(rem), .ovf(ovf), .dz(dz)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input int a, input int b);
        @(negedge ap_clk);
        din0   = 22'(a);
        din1   = 8'(b);
        in_vld = 1'b1;
        @(negedge ap_clk);
        in_vld = 1'b0;
    endtask

    task automatic op(input string tag, input int a, input int b, input int q_sat, input int q_wrap,
                      input int r, input int v, input int z, input int lat, input bit tog, input int hold);
        int n = 0;
        logic [13:0] d_keep;
        logic [7:0]  r_keep;
        start(a, b);
        while (!out_vld && n < 200) begin
            if (tog) ce = ~ce;
            @(negedge ap_clk);
            n++;
        end
        ce = 1'b1;
        chk({tag, " latency"}, n, lat);
        chk({tag, " dout"}, $signed(dout), SAT ? q_sat : q_wrap);
        chk({tag, " rem"}, $signed(rem), r);
        chk({tag, " ovf"}, int'(ovf), v);
        chk({tag, " dz"}, int'(dz), z);
        d_keep = dout;
        r_keep = rem;
        for (int i = 0; i < hold; i++) begin
            in_vld = i[0];
            din0   = 22'($urandom);
            din1   = 8'($urandom);
            @(negedge ap_clk);
            chk({tag, " hold dout"}, int'(dout), int'(d_keep));
            chk({tag, " hold rem"}, int'(rem), int'(r_keep));
            chk({tag, " hold in_rdy"}, int'(in_rdy), 0);
            chk({tag, " hold out_vld"}, int'(out_vld), 1);
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        @(negedge ap_clk);
        out_rdy = 1'b0;
        chk({tag, " idle in_rdy"}, int'(in_rdy), 1);
        chk({tag, " idle out_vld"}, int'(out_vld), 0);
        chk({tag, " idle flags"}, int'({ovf, dz}), 0);
    endtask

    initial begin
        #12;
        chk("reset in_rdy", int'(in_rdy), 1);
        chk("reset out_vld", int'(out_vld), 0);
        chk("reset dout", int'(dout), 0);
        chk("reset rem", int'(rem), 0);
        chk("reset flags", int'({ovf, dz}), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk("no spurious out_vld", int'(out_vld), 0);
        op("p_p", 1000, 7, 142, 142, 6, 0, 0, 23, 1'b0, 0);
        op("n_p", -1000, 7, -142, -142, -6, 0, 0, 23, 1'b0, 0);
        op("p_n", 1000, -7, -142, -142, 6, 0, 0, 23, 1'b0, 0);
        op("min_min", -2097152, -128, 8191, 0, 0, 1, 0, 23, 1'b0, 0);
        op("big", 100000, 3, 8191, 565, 1, 1, 0, 23, 1'b0, 0);
        op("neg_wrap", 2097151, -1, -8192, 1, 0, 1, 0, 23, 1'b0, 0);
        op("lo_edge", -8192, 1, -8192, -8192, 0, 0, 0, 23, 1'b0, 0);
        op("hi_edge", 8192, 1, 8191, -8192, 0, 1, 0, 23, 1'b0, 0);
        op("div_zero", -5, 0, -8192, 0, 0, 0, 1, 1, 1'b0, 0);
        op("hold", 1000, 7, 142, 142, 6, 0, 0, 23, 1'b0, 10);
        start(-1000, 7);
        repeat (10) @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("midreset in_rdy", int'(in_rdy), 1);
        chk("midreset out_vld", int'(out_vld), 0);
        chk("midreset dout", int'(dout), 0);
        chk("midreset rem", int'(rem), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);
        chk("post reset out_vld", int'(out_vld), 0);
        op("after_rst", 1000, 7, 142, 142, 6, 0, 0, 23, 1'b0, 0);
        op("ce_half", 1000, 7, 142, 142, 6, 0, 0, 46, 1'b1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnn_sdiv_22s_8s_14_seq.md
CNN_SDIV_22S_8S_14_SEQ -- requirements
Module: cnn_sdiv_22s_8s_14_seq

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ID  1  instance tag, no functional effect
  din0_WIDTH  22  signed dividend width
  din1_WIDTH  8  signed divisor width
  dout_WIDTH  14  signed quotient width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  ap_clk  in  1  sole clock, rising edge
  ap_rst_n  in  1  reset, asynchronous, active-low
  ce  in  1  clock enable; low freezes all state
  in_vld  in  1  operands valid
  in_rdy  out  1  block can accept operands
  din0  in  din0_WIDTH  signed dividend
  din1  in  din1_WIDTH  signed divisor
  out_vld  out  1  result valid
  out_rdy  in  1  consumer accepts result
  dout  out  dout_WIDTH  signed quotient
  rem  out  din1_WIDTH  signed remainder
  ovf  out  1  quotient saturated or wrapped
  dz  out  1  divisor was zero

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-004 in_rdy SHALL be 1 only in IDLE; it SHALL be a registered-state decode with no combinational path from in_vld.
REQ-005 Acceptance SHALL occur on an edge with ce=1, IDLE, in_vld=1: din0 and din1 captured, magnitudes and signs latched, iteration counter loaded with din0_WIDTH, state -> CALC.
REQ-006 In CALC, each ce=1 edge SHALL perform one restoring shift-subtract step on magnitudes; after din0_WIDTH (22) steps the next ce=1 edge SHALL apply sign correction, write dout/rem/ovf/dz, and move to DONE.
REQ-007 With ce held 1, out_vld SHALL rise exactly 23 edges after the accepting edge; ce=0 cycles SHALL stretch latency one-for-one.
REQ-008 Quotient SHALL truncate toward zero; remainder SHALL carry the dividend's sign, with |rem| < |din1| (C semantics).
REQ-009 Internal magnitude path SHALL be 22 bits for quotient and 9 bits for partial remainder so that -2^21 and -128 operands are exact.
REQ-010 In DONE, out_vld=1; dout, rem, ovf, dz SHALL hold stable until an edge with ce=1 and out_rdy=1, which returns the FSM to IDLE and clears out_vld.
REQ-011 in_vld outside IDLE SHALL be ignored; operands are not queued.
REQ-012 din1=0: no iterations; the FSM SHALL go to DONE on the edge after acceptance with dz=1, rem=0, ovf=0, dout per REQ-016.
REQ-013 dz and ovf SHALL be valid only while out_vld=1 and SHALL be 0 in IDLE.

Reset
REQ-014 ap_rst_n=0 SHALL immediately force IDLE, in_rdy=1 after release, out_vld=0, dout=0, rem=0, ovf=0, dz=0, counter=0, regardless of ce or current state (including mid-CALC; any in-flight operation is discarded).
REQ-015 The first acceptance after reset release SHALL require a ce=1 edge with in_vld=1; no spurious out_vld.

Configuration
REQ-016 Macro CNN_SDIV_SAT_EN defined: a true quotient outside [-8192, 8191] SHALL saturate to the nearer bound with ovf=1; divide-by-zero gives dout=8191 for din0>=0, -8192 for din0<0. Macro undefined: dout SHALL be the low 14 bits of the true quotient (two's-complement wrap), ovf=1 when wrap changes the value; divide-by-zero gives dout=0. rem SHALL be unaffected by the macro.

Verification
REQ-017 din0=1000, din1=7, ce=1 -> out_vld 23 edges after accept, dout=142, rem=6, ovf=0, dz=0.
REQ-018 (-1000,7) -> dout=-142, rem=-6; (1000,-7) -> dout=-142, rem=6; (-2097152,-128) -> dout=16384 true: SAT on 8191/ovf=1, off 0/ovf=1, rem=0.
REQ-019 din0=100000, din1=3 -> SAT on: dout=8191, ovf=1, rem=1; SAT off: dout=565, ovf=1, rem=1.
REQ-020 din0=-5, din1=0 -> dz=1, rem=0; SAT on dout=-8192, off dout=0; out_vld on second edge after accept.
REQ-021 Hold out_rdy=0 for 10 cycles in DONE while toggling in_vld/din -> outputs stable, in_rdy=0, no new accept; out_rdy=1 -> IDLE next edge.
REQ-022 Assert ap_rst_n=0 at step 10 of CALC -> outputs zero immediately; after release a new 1000/7 completes in 23 edges with correct result; ce toggled 50% -> latency doubles, result unchanged.
